// File: rtl/simple_uart_pkg.sv
// Shared constants and helpers for the simple UART blocks.
// Character framing and idle-timeout arithmetic.
package simple_uart_pkg;

    localparam int unsigned CHAR_BITS = 10;

    typedef enum logic {
        StEmpty,
        StHeld
    } stage_state_e;

    // Last idle-counter value before a gap of idle_chars characters has elapsed.
    function automatic int unsigned idle_max(
        input longint unsigned system_freq,
        input longint unsigned baud_rate,
        input longint unsigned idle_chars
    );
        longint unsigned ticks;
        ticks = idle_chars * 64'(CHAR_BITS) * system_freq / baud_rate;
        return 32'(ticks - 64'd1);
    endfunction

endpackage

// File: rtl/simple_uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop frees the head in the same cycle.
module simple_uart_sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clock,
    input  logic                       srst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       pop_empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             wr_en;
    logic             rd_en;

    assign level     = level_q;
    assign pop_empty = (level_q == '0);
    assign push_full = (level_q == LW'(DEPTH));
    assign rd_en     = pop && !pop_empty;
    assign wr_en     = push && (!push_full || rd_en);
    assign pop_data  = mem[rd_ptr_q];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow wraps modulo DEPTH.
    always_ff @(posedge clock) begin
        if (!srst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/simple_uart_rx_framer.sv
// Frames UART receiver bytes by line idle time and buffers them in a FWFT FIFO.
// The newest byte is staged until the next strobe or an idle timeout decides its last flag.
module simple_uart_rx_framer
    import simple_uart_pkg::*;
#(
    parameter int unsigned SYSTEM_FREQ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned IDLE_CHARS  = 3
) (
    input  logic                       clock,
    input  logic                       srst_n,
    input  logic [7:0]                 rx_value,
    input  logic                       rx_value_ready,
    output logic [7:0]                 out_data,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow,
    input  logic                       overflow_clear
);

    localparam int unsigned IdleMax = idle_max(64'(SYSTEM_FREQ), 64'(BAUD_RATE),
                                               64'(IDLE_CHARS));
    localparam int unsigned CntW    = (IdleMax > 0) ? $clog2(IdleMax + 1) : 1;

    stage_state_e    state_q;
    logic [7:0]      stage_data_q;
    logic [CntW-1:0] idle_cnt_q;
    logic            overflow_q;

    logic            timeout;
    logic            push;
    logic [8:0]      push_data;
    logic            pop;
    logic [8:0]      pop_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            dropped;

    assign timeout   = (state_q == StHeld) && (idle_cnt_q == CntW'(IdleMax));
    // A strobe coinciding with the timeout keeps the frame open.
    assign push      = (state_q == StHeld) && (rx_value_ready || timeout);
    assign push_data = {!rx_value_ready, stage_data_q};
    assign pop       = out_ready && !fifo_empty;
    assign dropped   = push && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (!srst_n) begin
            state_q      <= StEmpty;
            stage_data_q <= '0;
            idle_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (rx_value_ready) begin
                        stage_data_q <= rx_value;
                        idle_cnt_q   <= '0;
                        state_q      <= StHeld;
                    end
                end
                StHeld: begin
                    if (rx_value_ready) begin
                        stage_data_q <= rx_value;
                        idle_cnt_q   <= '0;
                    end else if (timeout) begin
                        idle_cnt_q <= '0;
                        state_q    <= StEmpty;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!srst_n) begin
            overflow_q <= 1'b0;
        end else if (dropped) begin
            overflow_q <= 1'b1;
        end else if (overflow_clear) begin
            overflow_q <= 1'b0;
        end
    end

    simple_uart_sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .srst_n    (srst_n),
        .push      (push),
        .push_data (push_data),
        .push_full (fifo_full),
        .pop       (pop),
        .pop_data  (pop_data),
        .pop_empty (fifo_empty),
        .level     (level)
    );

    assign out_data  = pop_data[7:0];
    assign out_last  = pop_data[8];
    assign out_valid = !fifo_empty;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_simple_uart_rx_framer.sv
// Self-checking bench for simple_uart_rx_framer: vector table plus corner-case sequences.
// Expected bytes are queued as stimulus is driven and compared as the stream pops them.
module tb_simple_uart_rx_framer;

    localparam int unsigned SYSTEM_FREQ = 400;
    localparam int unsigned BAUD_RATE   = 100;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned IDLE_CHARS  = 3;
    // 3 chars * 10 bits * 4 clocks/bit - 1
    localparam int unsigned IDLE_MAX    = 119;
    localparam int unsigned CHAR_CYC    = 40;
    localparam int unsigned LW          = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          srst_n;
    logic [7:0]    rx_value;
    logic          rx_value_ready;
    logic [7:0]    out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          overflow_clear;

    int unsigned   errors = 0;
    int unsigned   checks = 0;
    logic [8:0]    exp_q[$];
    logic [8:0]    mon_exp;

    typedef struct {
        logic [7:0]  data;
        int unsigned gap;
        logic        last;
    } vec_t;
    vec_t vecs[8];

    simple_uart_rx_framer #(
        .SYSTEM_FREQ (SYSTEM_FREQ),
        .BAUD_RATE   (BAUD_RATE),
        .DEPTH       (DEPTH),
        .IDLE_CHARS  (IDLE_CHARS)
    ) dut (
        .clock          (clock),
        .srst_n         (srst_n),
        .rx_value       (rx_value),
        .rx_value_ready (rx_value_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int unsigned n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // One-cycle receiver strobe; returns 1 time unit after the edge that samples it.
    task automatic strobe(input logic [7:0] b);
        rx_value       = b;
        rx_value_ready = 1'b1;
        @(posedge clock);
        #1;
        rx_value_ready = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 600) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h01, CHAR_CYC, 1'b0};
        vecs[1] = '{8'h02, CHAR_CYC, 1'b0};
        vecs[2] = '{8'h03, 130, 1'b1};
        vecs[3] = '{8'h11, IDLE_MAX + 1, 1'b0};
        vecs[4] = '{8'h12, IDLE_MAX + 2, 1'b1};
        vecs[5] = '{8'h13, 125, 1'b1};
        vecs[6] = '{8'h80, CHAR_CYC, 1'b0};
        vecs[7] = '{8'hFF, 200, 1'b1};

        srst_n         = 1'b0;
        rx_value       = 8'h00;
        rx_value_ready = 1'b0;
        out_ready      = 1'b0;
        overflow_clear = 1'b0;

        fork
            forever begin
                @(negedge clock);
                if (srst_n && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got %0h, expected no output",
                                 {out_last, out_data});
                    end else begin
                        mon_exp = exp_q.pop_front();
                        chk("pop_data", {23'd0, out_last, out_data}, {23'd0, mon_exp});
                    end
                end
            end
            begin
                #2_000_000;
                $display("FAIL watchdog: got timeout, expected completion");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        cycles(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_overflow", overflow, 0);
        srst_n = 1'b1;
        cycles(2);

        // Single byte: nothing pushed until IDLE_MAX+1 cycles after the strobe
        strobe(8'hA5);
        cycles(IDLE_MAX);
        chk("single_early_valid", out_valid, 0);
        chk("single_early_level", level, 0);
        cycles(1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_last", out_last, 1);
        chk("single_level", level, 1);
        exp_q.push_back({1'b1, 8'hA5});
        drain("single_drain");

        // Table-driven frames, including both sides of the timeout edge
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({vecs[i].last, vecs[i].data});
            strobe(vecs[i].data);
            cycles(vecs[i].gap - 1);
        end
        drain("table_drain");

        // Overflow: DEPTH+2 bytes with the consumer stalled; last two dropped
        out_ready = 1'b0;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            if (i < int'(DEPTH)) begin
                exp_q.push_back({1'b0, 8'h20 + 8'(i)});
            end
            strobe(8'h20 + 8'(i));
            cycles(CHAR_CYC - 1);
        end
        cycles(IDLE_MAX + 2);
        chk("ovf_level", level, DEPTH);
        chk("ovf_flag", overflow, 1);
        drain("ovf_drain");
        chk("ovf_sticky", overflow, 1);
        chk("ovf_level_empty", level, 0);
        overflow_clear = 1'b1;
        cycles(1);
        overflow_clear = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Push while full with a simultaneous pop: no drop
        for (int i = 0; i <= int'(DEPTH); i++) begin
            exp_q.push_back({1'b0, 8'h40 + 8'(i)});
            strobe(8'h40 + 8'(i));
            cycles(CHAR_CYC - 1);
        end
        chk("full_level", level, DEPTH);
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 8'h4F});
        strobe(8'h4F);
        out_ready = 1'b0;
        chk("fullpop_level", level, DEPTH);
        chk("fullpop_overflow", overflow, 0);
        drain("fullpop_drain");
        chk("fullpop_overflow_end", overflow, 0);

        // Reset mid-frame with a staged byte and level=3
        for (int i = 0; i < 4; i++) begin
            strobe(8'h60 + 8'(i));
            cycles(CHAR_CYC - 1);
        end
        chk("midrst_level_before", level, 3);
        srst_n         = 1'b0;
        rx_value       = 8'h77;
        rx_value_ready = 1'b1;
        @(posedge clock);
        #1;
        srst_n         = 1'b1;
        rx_value_ready = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_level", level, 0);
        cycles(200);
        chk("midrst_no_stale", out_valid, 0);
        exp_q.push_back({1'b1, 8'h5A});
        strobe(8'h5A);
        drain("midrst_5a");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
